// File: rtl/wbdma_busarb.sv
// Two-master Wishbone pipelined arbiter: CPU on port A, DMA on port B, one system bus.
// Optional hung-cycle abort is enabled by defining WBDMA_BUSARB_TIMEOUT_EN.
module wbdma_busarb #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LGOUT = 4,
  parameter int LGTMO = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  input  logic          i_stall,
  input  logic          i_err,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_rdata
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

  localparam logic [LGOUT:0] NOUT_MAX = (LGOUT+1)'((1 << LGOUT) - 1);
  localparam logic [LGOUT:0] NOUT_ONE = (LGOUT+1)'(1);

  owner_e         owner_q, owner_d;
  logic [LGOUT:0] nout_q, nout_d;
  logic           aborted_q, aborted_d;

  logic           own_b, abort, own_cyc, own_stb, oth_cyc;
  logic [LGOUT:0] nout;
  logic           own_stall, own_ack, own_err, tmo_pulse, accept;

  logic unused_lgtmo;
  assign unused_lgtmo = ^LGTMO;

  // Reset forces the reset-state view combinationally so B loses the bus at once.
  always_comb begin
    own_b   = (owner_q == OWN_B) & ~i_rst;
    abort   = aborted_q & ~i_rst;
    nout    = i_rst ? '0 : nout_q;
    own_cyc = own_b ? i_b_cyc : i_a_cyc;
    own_stb = own_b ? i_b_stb : i_a_stb;
    oth_cyc = own_b ? i_a_cyc : i_b_cyc;
    o_cyc   = own_cyc & ~abort;
    o_stb   = o_cyc & own_stb;
    o_we    = own_b ? i_b_we   : i_a_we;
    o_addr  = own_b ? i_b_addr : i_a_addr;
    o_data  = own_b ? i_b_data : i_a_data;
    o_rdata = i_data;
    accept    = o_stb & ~i_stall;
    own_stall = i_stall | (nout == NOUT_MAX) | abort;
    own_ack   = i_ack & o_cyc & (nout != '0);
    own_err   = (i_err & o_cyc) | tmo_pulse;
    o_a_stall = own_b ? 1'b1 : own_stall;
    o_a_ack   = own_b ? 1'b0 : own_ack;
    o_a_err   = own_b ? 1'b0 : own_err;
    o_b_stall = own_b ? own_stall : 1'b1;
    o_b_ack   = own_b ? own_ack : 1'b0;
    o_b_err   = own_b ? own_err : 1'b0;
  end

  always_comb begin
    owner_d = owner_q;
    if (!own_cyc && oth_cyc)
      owner_d = (owner_q == OWN_B) ? OWN_A : OWN_B;

    nout_d = nout_q;
    if (!o_cyc || i_err)
      nout_d = '0;
    else if (accept && !own_ack)
      nout_d = nout_q + NOUT_ONE;
    else if (!accept && own_ack)
      nout_d = nout_q - NOUT_ONE;

    aborted_d = aborted_q;
    if (!own_cyc)
      aborted_d = 1'b0;
    else if (own_err)
      aborted_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_q   <= OWN_A;
      nout_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      nout_q    <= nout_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef WBDMA_BUSARB_TIMEOUT_EN
  logic [LGTMO-1:0] timer_q, timer_d;

  // Counts only while the owner is waiting on the bus; any response restarts it.
  always_comb begin
    tmo_pulse = (timer_q == '1) & o_cyc & ~i_rst;
    timer_d   = timer_q;
    if (i_ack || i_err || !o_cyc || tmo_pulse)
      timer_d = '0;
    else if ((nout_q != '0) || o_stb)
      timer_d = timer_q + LGTMO'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      timer_q <= '0;
    else
      timer_q <= timer_d;
  end
`else
  assign tmo_pulse = 1'b0;
`endif

endmodule
